three_by_three_systolic: RTL and testbench
==========================================

// Module: three_by_three_systolic
// PURPOSE
// - Computes a valid-mode 2-D correlation of a 4x4 8-bit image (i00..i33) with a 3x3 8-bit kernel (f00..f22).
// - The result is a 2x2 output (o00..o11). oRC = sum over a,b in 0..2 of i[R+a][C+b]*f[a][b]. The kernel is not flipped.
// - The datapath is a weight-stationary 3x3 grid of MAC processing elements (PEs).
// - Sits as the compute core of a convolution layer. Operands are parallel buses; the results are registered outputs.
// PARAMETERS
// - DW  8   data width of pixels, weights and outputs
// - AW  20  internal accumulator width (9 products of 8x8 bits, no overflow)
// PORTS (positional order)
// - clk       in   1   rising-edge clock; the block uses this single clock
// - rst       in   1   reset, asynchronous, active-high
// - i00..i33  in   8   image pixel i[row][col], 16 ports, row-major
// - f00..f22  in   8   kernel weight f[row][col], 9 ports, row-major
// - o00,o01,o10,o11  out  8   output oRC (row R, column C), registered
// BEHAVIOUR
// - Reset (rst=1, asynchronous) clears the following to 0:
//   - all 9 PE weight registers, partial sums and pipeline registers
//   - the skew/feed registers and the sequencer counter
//   - all four outputs
// - Reset has priority over all other activity. Outputs hold 0 while rst=1.
// - Cycle 1 is the first rising edge with rst=0:
//   - f00..f22 load into PE(a,b) (stationary weights).
//   - i00..i33 are snapshotted into an internal frame register.
//   - Input changes after cycle 1 are ignored until the next reset.
// - Feed: the four windows enter the array in the order o00, o01, o10, o11, one window per cycle, starting at cycle 2.
//   - PE row a receives window-row a delayed by a cycles (diagonal skew).
//   - Partial sums move down each PE column, then are summed across the 3 columns in a final adder stage.
// - Latency, fixed:
//   - o00 updates at cycle 8, o01 at cycle 9, o10 at cycle 10, o11 at cycle 11.
//   - Each output register is written exactly once per run.
//   - Each output holds its value until the next reset.
//   - Before its update cycle, every output reads 0.
// - Sequencer states and transitions:
//   - IDLE (in reset) -> LOAD (cycle 1) -> RUN (cycles 2..11) -> DONE
//   - DONE holds until rst rises; only reset leaves DONE.
// - Arithmetic:
//   - Products and sums are unsigned.
//   - Accumulation is exact in AW bits.
//   - The output takes the low 8 bits (modulo 256) unless the option below is enabled.
// - Reset mid-operation: all state clears immediately. After release, the run restarts from LOAD using the current inputs.
// - Reset released then reasserted within 1 cycle: no output ever leaves 0.
// CONFIGURATION
// - Macro SYSTOLIC_SATURATE_EN.
//   - Defined: any AW-bit result above 255 drives the output to 8'd255 (unsigned saturation).
//   - Undefined: truncation modulo 256.
// - Latency and schedule are identical in both builds.
// TESTING
// - Clock period 10 ns, rst=1 for 200 ns then 0.
// - Image = 9 8 2 6 / 0 4 1 6 / 4 10 1 1 / 2 2 9 9. Kernel = 3 2 0 / 2 0 1 / 3 1 1.
//   - Required: o00=67, o01=74, o10=34, o11=59.
//   - Each value appears on its stated latency cycle and is held.
// - Same stimulus, rst pulsed high for 200 ns after 500 ns:
//   - All outputs go to 0 asynchronously, without a clock edge.
//   - After release, the same values 67/74/34/59 reappear with the same latency.
// - Change image inputs to all 1 at cycle 3 of a run: the outputs still equal 67/74/34/59 (snapshot at LOAD).
// - All pixels 255, all weights 255:
//   - Exact sum is 585225.
//   - Without SYSTOLIC_SATURATE_EN every output = 8'd9 (585225 mod 256).
//   - With SYSTOLIC_SATURATE_EN every output = 8'd255.
// - Identity kernel (f11=1, all other weights 0) with the image above: o00=4, o01=1, o10=10, o11=1.
// - Assert rst at cycle 9, between the o00 and o01 updates: all outputs read 0; the restarted run completes correctly.

Source files
------------

// File: rtl/three_by_three_systolic.sv
// Weight-stationary 3x3 systolic correlator: 4x4 frame * 3x3 kernel -> 2x2 registered outputs.
// Optional build macro SYSTOLIC_SATURATE_EN selects unsigned saturation instead of modulo-256 truncation.
module three_by_three_systolic #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i00, i01, i02, i03,
    input  logic [DW-1:0] i10, i11, i12, i13,
    input  logic [DW-1:0] i20, i21, i22, i23,
    input  logic [DW-1:0] i30, i31, i32, i33,
    input  logic [DW-1:0] f00, f01, f02,
    input  logic [DW-1:0] f10, f11, f12,
    input  logic [DW-1:0] f20, f21, f22,
    output logic [DW-1:0] o00, o01, o10, o11
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] img      [4][4];
    logic [DW-1:0] ker      [3][3];
    logic [DW-1:0] frame_q  [4][4], frame_d [4][4];
    logic [DW-1:0] wt_q     [3][3], wt_d    [3][3];
    logic [DW-1:0] win      [3][3];
    logic [DW-1:0] x_q      [3][3], x_d     [3][3];
    logic [DW-1:0] d1_q     [3],    d1_d    [3];
    logic [DW-1:0] d2a_q    [3],    d2a_d   [3];
    logic [DW-1:0] d2b_q    [3],    d2b_d   [3];
    logic [AW-1:0] ps_q     [3][3], ps_d    [3][3];
    logic [AW-1:0] sum_q, sum_d;
    logic [DW-1:0] res_q, res_d;
    logic [DW-1:0] out_q    [4],    out_d   [4];
    logic [1:0]    widx;
    logic          feed_en;

    function automatic logic [DW-1:0] clip(input logic [AW-1:0] v);
`ifdef SYSTOLIC_SATURATE_EN
        return (v > AW'({DW{1'b1}})) ? {DW{1'b1}} : DW'(v);
`else
        return DW'(v);
`endif
    endfunction

    assign img = '{'{i00, i01, i02, i03}, '{i10, i11, i12, i13},
                   '{i20, i21, i22, i23}, '{i30, i31, i32, i33}};
    assign ker = '{'{f00, f01, f02}, '{f10, f11, f12}, '{f20, f21, f22}};

    assign o00 = out_q[0];
    assign o01 = out_q[1];
    assign o10 = out_q[2];
    assign o11 = out_q[3];

    // Sequencer: cnt_q equals the number of clock edges since reset release until DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = LOAD;
                cnt_d   = 4'd1;
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = cnt_q + 4'd1;
            end
            RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d = (state_q == IDLE) ? img : frame_q;
        wt_d    = (state_q == IDLE) ? ker : wt_q;
        feed_en = (cnt_q >= 4'd1) && (cnt_q <= 4'd4);
        widx    = 2'(cnt_q - 4'd1);

        // Window origin: bit 1 selects the row offset, bit 0 the column offset.
        for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) begin
                win[a][b] = frame_q[a][b];
                case (widx)
                    2'd1:    win[a][b] = frame_q[a][b+1];
                    2'd2:    win[a][b] = frame_q[a+1][b];
                    2'd3:    win[a][b] = frame_q[a+1][b+1];
                    default: win[a][b] = frame_q[a][b];
                endcase
            end
        end

        // Diagonal skew: PE row a sees its window row a cycles after row 0.
        for (int b = 0; b < 3; b++) begin
            x_d[0][b] = feed_en ? win[0][b] : '0;
            d1_d[b]   = feed_en ? win[1][b] : '0;
            d2a_d[b]  = feed_en ? win[2][b] : '0;
            d2b_d[b]  = d2a_q[b];
            x_d[1][b] = d1_q[b];
            x_d[2][b] = d2b_q[b];
        end

        // Partial sums flow down each PE column.
        for (int b = 0; b < 3; b++) begin
            ps_d[0][b] = AW'(x_q[0][b]) * AW'(wt_q[0][b]);
            for (int a = 1; a < 3; a++) begin
                ps_d[a][b] = ps_q[a-1][b] + AW'(x_q[a][b]) * AW'(wt_q[a][b]);
            end
        end

        sum_d = ps_q[2][0] + ps_q[2][1] + ps_q[2][2];
        res_d = clip(sum_q);

        out_d = out_q;
        for (int k = 0; k < 4; k++) begin
            if ((state_q == RUN) && (cnt_q == 4'(7 + k))) out_d[k] = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '{default: '0};
            wt_q    <= '{default: '0};
            x_q     <= '{default: '0};
            d1_q    <= '{default: '0};
            d2a_q   <= '{default: '0};
            d2b_q   <= '{default: '0};
            ps_q    <= '{default: '0};
            sum_q   <= '0;
            res_q   <= '0;
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            wt_q    <= wt_d;
            x_q     <= x_d;
            d1_q    <= d1_d;
            d2a_q   <= d2a_d;
            d2b_q   <= d2b_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_three_by_three_systolic.sv
// Directed bench for three_by_three_systolic: hand-computed correlation results and cycle-exact latency.
module tb_three_by_three_systolic;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] img [16];
    logic [7:0] ker [9];
    logic [7:0] o00, o01, o10, o11;
    int         vectors     = 0;
    int         miscompares = 0;

    localparam logic [7:0] IMG0 [16] = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
    localparam logic [7:0] KER0 [9]  = '{3, 2, 0, 2, 0, 1, 3, 1, 1};

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic [7:0] BIG = 8'd255;
`else
    localparam logic [7:0] BIG = 8'd9;
`endif

    always #5 clk = ~clk;

    three_by_three_systolic dut (
        .clk(clk), .rst(rst),
        .i00(img[0]),  .i01(img[1]),  .i02(img[2]),  .i03(img[3]),
        .i10(img[4]),  .i11(img[5]),  .i12(img[6]),  .i13(img[7]),
        .i20(img[8]),  .i21(img[9]),  .i22(img[10]), .i23(img[11]),
        .i30(img[12]), .i31(img[13]), .i32(img[14]), .i33(img[15]),
        .f00(ker[0]), .f01(ker[1]), .f02(ker[2]),
        .f10(ker[3]), .f11(ker[4]), .f12(ker[5]),
        .f20(ker[6]), .f21(ker[7]), .f22(ker[8]),
        .o00(o00), .o01(o01), .o10(o10), .o11(o11)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " o00"}, o00, 8'd0);
        chk({tag, " o01"}, o01, 8'd0);
        chk({tag, " o10"}, o10, 8'd0);
        chk({tag, " o11"}, o11, 8'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset at a falling edge, confirm the async clear, release after n falling edges.
    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("async_clear");
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Call right after reset release; checks every output on cycles 1..13.
    task automatic check_run(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input int chg);
        for (int k = 1; k <= 13; k++) begin
            if (k == chg) for (int n = 0; n < 16; n++) img[n] = 8'd1;
            tick();
            chk($sformatf("%s o00 c%0d", tag, k), o00, (k >= 8)  ? e0 : 8'd0);
            chk($sformatf("%s o01 c%0d", tag, k), o01, (k >= 9)  ? e1 : 8'd0);
            chk($sformatf("%s o10 c%0d", tag, k), o10, (k >= 10) ? e2 : 8'd0);
            chk($sformatf("%s o11 c%0d", tag, k), o11, (k >= 11) ? e3 : 8'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        img = IMG0;
        ker = KER0;
        #100;
        check_zero("in_reset");
        #100;
        rst = 1'b0;
        check_run("basic", 8'd67, 8'd74, 8'd34, 8'd59, 0);
        repeat (3) tick();
        chk("hold o00", o00, 8'd67);
        chk("hold o11", o11, 8'd59);

        // Asynchronous pulse at 500 ns, released at 700 ns.
        #(64'd500 - $time);
        rst = 1'b1;
        #1;
        check_zero("pulse_async");
        #199;
        rst = 1'b0;
        check_run("after_pulse", 8'd67, 8'd74, 8'd34, 8'd59, 0);

        // Image changes at cycle 3 must not disturb the snapshot.
        apply_reset(2);
        check_run("snapshot", 8'd67, 8'd74, 8'd34, 8'd59, 3);
        img = IMG0;

        // All-ones operands: exact sum 585225.
        for (int n = 0; n < 16; n++) img[n] = 8'd255;
        for (int n = 0; n < 9; n++)  ker[n] = 8'd255;
        apply_reset(2);
        check_run("max", BIG, BIG, BIG, BIG, 0);
        img = IMG0;

        // Identity kernel picks the window centres.
        for (int n = 0; n < 9; n++) ker[n] = 8'd0;
        ker[4] = 8'd1;
        apply_reset(2);
        check_run("identity", 8'd4, 8'd1, 8'd10, 8'd1, 0);
        ker = KER0;

        // Reset between the o00 and o01 updates.
        apply_reset(2);
        repeat (8) tick();
        chk("mid o00 c8", o00, 8'd67);
        chk("mid o01 c8", o01, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        tick();
        check_zero("mid_reset_held");
        @(negedge clk);
        rst = 1'b0;
        check_run("mid_restart", 8'd67, 8'd74, 8'd34, 8'd59, 0);

        // One-cycle release followed by reassertion.
        apply_reset(2);
        tick();
        check_zero("glitch_c1");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_zero($sformatf("glitch_hold%0d", k));
        end
        @(negedge clk);
        rst = 1'b0;
        check_run("glitch_restart", 8'd67, 8'd74, 8'd34, 8'd59, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
